// File: rtl/conv_window_ctrl_if.sv
// Pixel-stream handshake and window-tag bundle between the line-buffer
// sequencer (slave) and its upstream/downstream neighbours (master).
interface conv_window_ctrl_if #(
  parameter int CW = 8
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          sr_ce;
  logic          win_valid;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          busy;
  logic          done;
  logic          err;

  modport slave (
    input  start, in_valid,
    output in_ready, sr_ce, win_valid, win_row, win_col, busy, done, err
  );

  modport master (
    output start, in_valid,
    input  in_ready, sr_ce, win_valid, win_row, win_col, busy, done, err
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the KxK line-buffer window: drives the shared shift
// enable, tags stride-aligned windows with output coordinates, aborts on underrun.
module conv_window_ctrl #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int CW     = 8
) (
  input  logic                clk,
  input  logic                rst,
  conv_window_ctrl_if.slave   bus
);

  if (K < 1 || STRIDE < 1 || IMG_W < K || IMG_H < K ||
      IMG_W > (1 << CW) - 1 || IMG_H > (1 << CW) - 1) begin : g_bad_params
    $error("conv_window_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] KM1    = CW'(K - 1);
  localparam logic [CW-1:0] W_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] H_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] S_LAST = CW'(STRIDE - 1);
  localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t        state_r, state_s;
  logic          in_ready_r, busy_r, done_r, err_r, started_r;
  logic          win_valid_r;
  logic [CW-1:0] win_row_r, win_col_r;
  logic [CW-1:0] r_r, c_r, rph_r, cph_r, orow_r, ocol_r;
  logic          accept_s, underrun_s, last_px_s;
  logic          qual_row_s, qual_col_s, qual_s, sr_ce_s;

  assign accept_s   = bus.in_valid & (state_r == S_RUN);
  assign underrun_s = ~bus.in_valid & started_r & (state_r == S_RUN);
  assign last_px_s  = accept_s & (r_r == H_LAST) & (c_r == W_LAST);
  // Phase counters are zero exactly on stride-aligned rows/columns past K-1.
  assign qual_row_s = (r_r >= KM1) & (rph_r == ZERO);
  assign qual_col_s = (c_r >= KM1) & (cph_r == ZERO);
  assign qual_s     = accept_s & qual_row_s & qual_col_s;

  // Next-state decode and the combinational shift enable.
  always_comb begin
    state_s = state_r;
    sr_ce_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) state_s = S_RUN;
        else           state_s = S_IDLE;
      end
      S_RUN: begin
        sr_ce_s = bus.in_valid;
        if (underrun_s)     state_s = S_IDLE;
        else if (last_px_s) state_s = S_DONE;
        else                state_s = S_RUN;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register with registered status decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == S_RUN);
      busy_r     <= (state_s != S_IDLE);
      done_r     <= (state_s == S_DONE);
    end
  end

  // Raster position, stride phases, output indices and window tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r         <= ZERO;
      c_r         <= ZERO;
      rph_r       <= ZERO;
      cph_r       <= ZERO;
      orow_r      <= ZERO;
      ocol_r      <= ZERO;
      started_r   <= 1'b0;
      err_r       <= 1'b0;
      win_valid_r <= 1'b0;
      win_row_r   <= ZERO;
      win_col_r   <= ZERO;
    end else begin
      win_valid_r <= qual_s;
      if (state_r == S_IDLE && bus.start) begin
        r_r       <= ZERO;
        c_r       <= ZERO;
        rph_r     <= ZERO;
        cph_r     <= ZERO;
        orow_r    <= ZERO;
        ocol_r    <= ZERO;
        started_r <= 1'b0;
        err_r     <= 1'b0;
        win_row_r <= ZERO;
        win_col_r <= ZERO;
      end
      if (accept_s) begin
        started_r <= 1'b1;
        if (qual_s) begin
          win_row_r <= orow_r;
          win_col_r <= ocol_r;
        end
        if (c_r == W_LAST) begin
          c_r    <= ZERO;
          cph_r  <= ZERO;
          ocol_r <= ZERO;
          r_r    <= r_r + ONE;
          // Rows before K-1 hold phase 0 so row K-1 starts aligned.
          if (r_r < KM1)            rph_r <= ZERO;
          else if (rph_r == S_LAST) rph_r <= ZERO;
          else                      rph_r <= rph_r + ONE;
          if (qual_row_s) orow_r <= orow_r + ONE;
        end else begin
          c_r <= c_r + ONE;
          if (c_r < KM1)            cph_r <= ZERO;
          else if (cph_r == S_LAST) cph_r <= ZERO;
          else                      cph_r <= cph_r + ONE;
          if (qual_s) ocol_r <= ocol_r + ONE;
        end
      end
      if (underrun_s) err_r <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.sr_ce     = sr_ce_s;
  assign bus.win_valid = win_valid_r;
  assign bus.win_row   = win_row_r;
  assign bus.win_col   = win_col_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench: three sequencer configurations driven from cycle tables
// plus hand-written underrun and mid-frame reset sequences.
module tb_conv_window_ctrl;

  typedef struct {
    bit         start;
    bit         in_valid;
    bit         in_ready;
    bit         sr_ce;
    bit         win_valid;
    logic [7:0] win_row;
    logic [7:0] win_col;
    bit         busy;
    bit         done;
    bit         err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drv_start = 1'b0;
  logic drv_valid = 1'b0;
  int   sel = 0;

  int n_chk  = 0;
  int n_pass = 0;
  int hold_row [3];
  int hold_col [3];
  vec_t vq[$];

  logic       o_rdy, o_ce, o_wv, o_busy, o_done, o_err;
  logic [7:0] o_row, o_col;

  always #5 clk = ~clk;

  conv_window_ctrl_if #(.CW(8)) if_s1 ();
  conv_window_ctrl_if #(.CW(8)) if_s2 ();
  conv_window_ctrl_if #(.CW(8)) if_k4 ();

  assign if_s1.start    = (sel == 0) ? drv_start : 1'b0;
  assign if_s1.in_valid = (sel == 0) ? drv_valid : 1'b0;
  assign if_s2.start    = (sel == 1) ? drv_start : 1'b0;
  assign if_s2.in_valid = (sel == 1) ? drv_valid : 1'b0;
  assign if_k4.start    = (sel == 2) ? drv_start : 1'b0;
  assign if_k4.in_valid = (sel == 2) ? drv_valid : 1'b0;

  conv_window_ctrl #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(1), .CW(8)) u_s1 (
    .clk(clk), .rst(rst), .bus(if_s1));
  conv_window_ctrl #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2), .CW(8)) u_s2 (
    .clk(clk), .rst(rst), .bus(if_s2));
  conv_window_ctrl #(.IMG_W(4), .IMG_H(4), .K(4), .STRIDE(1), .CW(8)) u_k4 (
    .clk(clk), .rst(rst), .bus(if_k4));

  always_comb begin
    o_rdy = if_s1.in_ready; o_ce = if_s1.sr_ce; o_wv = if_s1.win_valid;
    o_row = if_s1.win_row;  o_col = if_s1.win_col; o_busy = if_s1.busy;
    o_done = if_s1.done;    o_err = if_s1.err;
    case (sel)
      1: begin
        o_rdy = if_s2.in_ready; o_ce = if_s2.sr_ce; o_wv = if_s2.win_valid;
        o_row = if_s2.win_row;  o_col = if_s2.win_col; o_busy = if_s2.busy;
        o_done = if_s2.done;    o_err = if_s2.err;
      end
      2: begin
        o_rdy = if_k4.in_ready; o_ce = if_k4.sr_ce; o_wv = if_k4.win_valid;
        o_row = if_k4.win_row;  o_col = if_k4.win_col; o_busy = if_k4.busy;
        o_done = if_k4.done;    o_err = if_k4.err;
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input bit st, input bit iv, input bit rdy, input bit ce,
                              input bit wv, input int row, input int col,
                              input bit bsy, input bit dn, input bit er);
    vec_t v;
    v.start = st; v.in_valid = iv; v.in_ready = rdy; v.sr_ce = ce; v.win_valid = wv;
    v.win_row = row[7:0]; v.win_col = col[7:0]; v.busy = bsy; v.done = dn; v.err = er;
    return v;
  endfunction

  // Expected cycle table for one gap-free frame (with one wait cycle before
  // the first pixel, a stray start mid-frame and in_valid held through DONE/IDLE).
  task automatic build_frame(input int w, input int h, input int k, input int s,
                             input bit err_before, input int d);
    int r, c;
    bit pwv;
    int hr, hc;
    hr = hold_row[d];
    hc = hold_col[d];
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hr, hc, 1'b0, 1'b0, err_before));
    hr = 0; hc = 0;
    vq.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, hr, hc, 1'b1, 1'b0, 1'b0));
    pwv = 1'b0;
    for (int n = 0; n < w * h; n++) begin
      vq.push_back(mk(n == 5, 1'b1, 1'b1, 1'b1, pwv, hr, hc, 1'b1, 1'b0, 1'b0));
      r = n / w;
      c = n % w;
      pwv = (r >= k - 1) && (c >= k - 1) && ((r - k + 1) % s == 0) && ((c - k + 1) % s == 0);
      if (pwv) begin
        hr = (r - k + 1) / s;
        hc = (c - k + 1) / s;
      end
    end
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, pwv, hr, hc, 1'b1, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, hr, hc, 1'b0, 1'b0, 1'b0));
    hold_row[d] = hr;
    hold_col[d] = hc;
  endtask

  task automatic run_table(input string tag, output int wins);
    wins = 0;
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      drv_start = vq[i].start;
      drv_valid = vq[i].in_valid;
      @(negedge clk);
      if (o_wv === 1'b1) wins++;
      chk($sformatf("%s.r%0d.in_ready", tag, i), o_rdy, vq[i].in_ready);
      chk($sformatf("%s.r%0d.sr_ce", tag, i), o_ce, vq[i].sr_ce);
      chk($sformatf("%s.r%0d.win_valid", tag, i), o_wv, vq[i].win_valid);
      chk($sformatf("%s.r%0d.win_row", tag, i), o_row, vq[i].win_row);
      chk($sformatf("%s.r%0d.win_col", tag, i), o_col, vq[i].win_col);
      chk($sformatf("%s.r%0d.busy", tag, i), o_busy, vq[i].busy);
      chk($sformatf("%s.r%0d.done", tag, i), o_done, vq[i].done);
      chk($sformatf("%s.r%0d.err", tag, i), o_err, vq[i].err);
    end
    vq.delete();
    @(posedge clk);
    #1;
    drv_start = 1'b0;
    drv_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".in_ready"}, o_rdy, 32'd0);
    chk({tag, ".sr_ce"}, o_ce, 32'd0);
    chk({tag, ".win_valid"}, o_wv, 32'd0);
    chk({tag, ".win_row"}, o_row, 32'd0);
    chk({tag, ".win_col"}, o_col, 32'd0);
    chk({tag, ".busy"}, o_busy, 32'd0);
    chk({tag, ".done"}, o_done, 32'd0);
    chk({tag, ".err"}, o_err, 32'd0);
  endtask

  initial begin
    int wins;
    for (int d = 0; d < 3; d++) begin
      hold_row[d] = 0;
      hold_col[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      chk_all_zero($sformatf("reset.d%0d", d));
    end

    // Basic 5x5 K=3 stride 1 frame
    sel = 0;
    build_frame(5, 5, 3, 1, 1'b0, 0);
    run_table("s1", wins);
    chk("s1.win_count", wins, 9);

    // Stride 2
    sel = 1;
    build_frame(5, 5, 3, 2, 1'b0, 1);
    run_table("s2", wins);
    chk("s2.win_count", wins, 4);

    // Degenerate: K equals the image size
    sel = 2;
    build_frame(4, 4, 4, 1, 1'b0, 2);
    run_table("k4", wins);
    chk("k4.win_count", wins, 1);

    // Underrun after 7 accepts
    sel = 0;
    @(posedge clk); #1; drv_start = 1'b1; drv_valid = 1'b0;
    @(posedge clk); #1; drv_start = 1'b0; drv_valid = 1'b1;
    repeat (7) @(posedge clk);
    #1; drv_valid = 1'b0;
    #1;
    chk("under.sr_ce", o_ce, 32'd0);
    chk("under.in_ready", o_rdy, 32'd1);
    chk("under.err_pre", o_err, 32'd0);
    @(posedge clk); #1;
    chk("under.err", o_err, 32'd1);
    chk("under.busy", o_busy, 32'd0);
    chk("under.in_ready_idle", o_rdy, 32'd0);
    hold_row[0] = 0;
    hold_col[0] = 0;
    drv_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("under.idle%0d.sr_ce", i), o_ce, 32'd0);
      chk($sformatf("under.idle%0d.win_valid", i), o_wv, 32'd0);
      chk($sformatf("under.idle%0d.done", i), o_done, 32'd0);
      chk($sformatf("under.idle%0d.err", i), o_err, 32'd1);
    end
    @(posedge clk); #1; drv_valid = 1'b0;
    build_frame(5, 5, 3, 1, 1'b1, 0);
    run_table("s1_after_err", wins);
    chk("s1_after_err.win_count", wins, 9);

    // Mid-frame asynchronous reset after 15 accepts
    @(posedge clk); #1; drv_start = 1'b1; drv_valid = 1'b0;
    @(posedge clk); #1; drv_start = 1'b0; drv_valid = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("midrst.pre_win_valid", o_wv, 32'd1);
    chk("midrst.pre_win_col", o_col, 32'd2);
    chk("midrst.pre_busy", o_busy, 32'd1);
    #1; rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    drv_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      hold_row[d] = 0;
      hold_col[d] = 0;
    end
    build_frame(5, 5, 3, 1, 1'b0, 0);
    run_table("s1_after_rst", wins);
    chk("s1_after_rst.win_count", wins, 9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Sequencer for the convolution line-buffer datapath. Accepts one raster-scanned image frame as a pixel stream and drives the shared clock-enable of the variable-length shift registers that form the K×K window. Flags every cycle in which the buffers hold a complete, stride-aligned window, tags that window with its output coordinates, and aborts cleanly on stream underrun. The buffers clear whenever their enable is low, so this block must never hold `sr_ce` low in the middle of a frame while valid data is still expected.

## Interface
Parameters:
- `IMG_W`, 8: image width in pixels; legal range K ≤ IMG_W ≤ 2^CW−1.
- `IMG_H`, 8: image height in rows; legal range K ≤ IMG_H ≤ 2^CW−1.
- `K`, 3: window size (K×K), at least 1.
- `STRIDE`, 1: window stride, at least 1.
- `CW`, 8: width of all row, column and coordinate counters.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle frame start; sampled only in IDLE.
- `in_valid`  in  1  upstream pixel present.
- `in_ready`  out  1  block is accepting pixels.
- `sr_ce`  out  1  shift-register enable, combinational.
- `win_valid`  out  1  window in the buffers is complete and aligned.
- `win_row`  out  CW  output-row index of the current window.
- `win_col`  out  CW  output-column index of the current window.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse on normal end of frame.
- `err`  out  1  sticky underrun flag.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE to RUN:** on `start`. This clears the row counter `r`, column counter `c`, stride phase counters and output indices, and clears `err`.
- **RUN:** `in_ready` is 1.
  - `sr_ce = in_valid & (state==RUN)`.
  - An accept is `in_valid & in_ready`.
  - On each accept, `c` increments. When `c` reaches IMG_W−1 it wraps to 0 and `r` increments.
- **Underrun:** `in_valid` low in RUN after the first pixel of the frame has been accepted.
  - The next state is IDLE and `err` is set to 1.
  - `sr_ce` is 0 in that cycle (the buffers clear).
  - No further `win_valid` or `done` is produced.
  - Before the first accept, `in_valid` low is legal waiting.
- **RUN to DONE:** on the accept of pixel (IMG_H−1, IMG_W−1).
- **DONE to IDLE:** unconditionally after one cycle.
- **Window condition** for the accepted pixel at (r, c):
  - r ≥ K−1 and c ≥ K−1;
  - (r−K+1) mod STRIDE = 0 and (c−K+1) mod STRIDE = 0.
  - The modulo is implemented with phase counters that reset at r = K−1 and c = K−1. No dividers.
- **Output indices:**
  - `win_col` counts from 0 on qualifying columns within a row.
  - `win_row` counts from 0 on qualifying rows.
  - `win_row`/`win_col` hold their value when `win_valid` is 0.
- **Ignored inputs:** `start` outside IDLE is ignored. `in_valid` in IDLE or DONE is ignored (`in_ready`=0, `sr_ce`=0).
- **Parameters:** illegal combinations are a static error (elaboration assertion). They are not handled at runtime.

## Timing
- **Reset values:** state IDLE; `in_ready`=0, `sr_ce`=0, `win_valid`=0, `win_row`=0, `win_col`=0, `busy`=0, `done`=0, `err`=0.
- **Mid-frame reset:** `rst` in the middle of a frame returns to these values immediately (asynchronously).
- **Accept timing:** `sr_ce` is high in the same cycle as the accept, so the buffers shift on that edge.
- **Window timing:** `win_valid`, `win_row` and `win_col` are registered. They are asserted in cycle t+1 for a qualifying accept at cycle t, aligned with the updated buffer contents.
- **Window rate:** at most one `win_valid` per accept. There are back-to-back windows for STRIDE=1.
- **Done timing:** `done` is high in the DONE cycle. That is t+1 after the final accept, coincident with the last `win_valid`.
- **Busy:** `busy`=1 in RUN and DONE.
- **Latency:** a gap-free frame lasts IMG_W·IMG_H accept cycles plus the DONE cycle. The next `start` is accepted from the cycle after DONE.
- **Window count:** the total windows per frame is ((IMG_H−K)/STRIDE+1)·((IMG_W−K)/STRIDE+1), using integer division.

## Test plan
- **Basic frame** (IMG_W=IMG_H=5, K=3, STRIDE=1): `start`, then 25 contiguous pixels.
  - First `win_valid` one cycle after the 13th accept, with (0,0).
  - 9 windows in total, last at (2,2).
  - `done` coincides with the last window.
- **Stride 2** (5×5, K=3): exactly 4 windows, at output (0,0), (0,1), (1,0), (1,1). They follow pixels (2,2), (2,4), (4,2), (4,4).
- **Underrun:** `in_valid` drops after 7 accepts.
  - `sr_ce`=0 in that cycle, and `err`=1 from the next cycle.
  - State returns to IDLE, with no `done` and no `win_valid`.
  - A new `start` clears `err`.
- **Mid-frame reset:** `rst` asserted after 15 accepts. All outputs go to 0 immediately. A following full frame reproduces the basic-frame results.
- **Ignored inputs:** `start` pulsed during RUN, and `in_valid` high during IDLE/DONE, cause no state change and no `sr_ce`.
- **Degenerate window** (K=IMG_W=IMG_H=4): exactly one window, (0,0), after the 16th accept, together with `done`.
